// File: rtl/spi_nbytes_tx.sv
// SPI mode-0 master that forwards one parity-checked N-byte frame per transaction
// and captures the MISO word shifted in alongside it.
module spi_nbytes_tx #(
  parameter int BYTE_NUM    = 4,
  parameter int SPI_CLK_DIV = 25
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*BYTE_NUM-1:0]   data_i,
  input  logic                    data_valid_i,
  input  logic                    crc_valid_i,
  input  logic                    spi_miso_i,
  output logic                    spi_sclk_o,
  output logic                    spi_mosi_o,
  output logic                    spi_cs_n_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    drop_o,
  output logic [8*BYTE_NUM-1:0]   rx_data_o
);

  localparam int N     = 8 * BYTE_NUM;
  localparam int BIT_W = $clog2(N + 1);
  localparam logic [7:0]       DIV_LAST = 8'(SPI_CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_div_cnt, w_div_nxt;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_nxt;
  logic [N-1:0]       r_tx_sr, w_tx_nxt;
  logic [N-1:0]       r_rx_sr, w_rx_nxt;
  logic [N-1:0]       r_rx_data, w_rx_data_nxt;
  logic               r_sclk, w_sclk_nxt;
  logic               r_mosi, w_mosi_nxt;
  logic               r_cs_n, w_cs_n_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_drop, w_drop_nxt;
  logic               w_tick;
  logic               w_accept;

  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign w_accept = (r_state == ST_IDLE) && data_valid_i && crc_valid_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SETUP;
        else          w_state_nxt = ST_IDLE;
      end
      ST_SETUP: begin
        if (w_tick) w_state_nxt = ST_SHIFT;
        else        w_state_nxt = ST_SETUP;
      end
      ST_SHIFT: begin
        if (w_tick && !r_sclk && (r_bit_cnt == BIT_LAST)) w_state_nxt = ST_HOLD;
        else                                              w_state_nxt = ST_SHIFT;
      end
      ST_HOLD: begin
        if (w_tick) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_HOLD;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Divider, bit counter and shift registers; bit counter counts SCLK rising edges
  always_comb begin
    w_div_nxt  = r_div_cnt;
    w_bit_nxt  = r_bit_cnt;
    w_tx_nxt   = r_tx_sr;
    w_rx_nxt   = r_rx_sr;
    w_sclk_nxt = r_sclk;
    case (r_state)
      ST_IDLE: begin
        w_div_nxt  = 8'd0;
        w_bit_nxt  = BIT_ZERO;
        w_sclk_nxt = 1'b0;
        if (w_accept) begin
          w_tx_nxt = data_i;
          w_rx_nxt = {N{1'b0}};
        end else begin
          w_tx_nxt = r_tx_sr;
          w_rx_nxt = r_rx_sr;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_div_nxt  = 8'd0;
          w_sclk_nxt = 1'b1;
          w_rx_nxt   = {r_rx_sr[N-2:0], spi_miso_i};
          w_bit_nxt  = BIT_ONE;
        end else begin
          w_div_nxt  = r_div_cnt + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          w_div_nxt = 8'd0;
          if (r_sclk) begin
            // Falling edge: MOSI holds bit 0 after the final one
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt != BIT_LAST) w_tx_nxt = {r_tx_sr[N-2:0], 1'b0};
            else                       w_tx_nxt = r_tx_sr;
          end else if (r_bit_cnt == BIT_LAST) begin
            w_sclk_nxt = 1'b0;
          end else begin
            w_sclk_nxt = 1'b1;
            w_rx_nxt   = {r_rx_sr[N-2:0], spi_miso_i};
            w_bit_nxt  = r_bit_cnt + BIT_ONE;
          end
        end else begin
          w_div_nxt = r_div_cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (w_tick) w_div_nxt = 8'd0;
        else        w_div_nxt = r_div_cnt + 8'd1;
      end
      ST_DONE: begin
        w_div_nxt = 8'd0;
        w_bit_nxt = BIT_ZERO;
      end
      default: begin
        w_div_nxt  = 8'd0;
        w_bit_nxt  = BIT_ZERO;
        w_sclk_nxt = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    w_cs_n_nxt    = 1'b1;
    w_busy_nxt    = 1'b0;
    w_mosi_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_rx_data_nxt = r_rx_data;
    w_drop_nxt    = data_valid_i && !w_accept;
    case (w_state_nxt)
      ST_SETUP, ST_SHIFT, ST_HOLD: begin
        w_cs_n_nxt = 1'b0;
        w_busy_nxt = 1'b1;
        w_mosi_nxt = w_tx_nxt[N-1];
      end
      ST_DONE: begin
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b1;
        w_rx_data_nxt = r_rx_sr;
      end
      ST_IDLE: begin
        w_cs_n_nxt = 1'b1;
      end
      default: begin
        w_cs_n_nxt = 1'b1;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div_cnt <= 8'd0;
      r_bit_cnt <= BIT_ZERO;
      r_tx_sr   <= {N{1'b0}};
      r_rx_sr   <= {N{1'b0}};
      r_rx_data <= {N{1'b0}};
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx_sr   <= w_tx_nxt;
      r_rx_sr   <= w_rx_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign spi_sclk_o = r_sclk;
  assign spi_mosi_o = r_mosi;
  assign spi_cs_n_o = r_cs_n;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign drop_o     = r_drop;
  assign rx_data_o  = r_rx_data;

endmodule

// File: tb/tb_spi_nbytes_tx.sv
// Randomised bench for spi_nbytes_tx: a 4-byte/DIV=2 instance and a 1-byte/DIV=3 instance,
// checked against transaction-level expectations (latency, edge counts, bit order, captured word).
module tb_spi_nbytes_tx;

  localparam int N_A   = 32;
  localparam int DIV_A = 2;
  localparam int N_B   = 8;
  localparam int DIV_B = 3;
  localparam int LAT_A = 1 + 2 * DIV_A * (N_A + 1);
  localparam int LAT_B = 1 + 2 * DIV_B * (N_B + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_data = 32'd0;
  logic        a_dv = 1'b0, a_crc = 1'b0, a_loop = 1'b0, a_miso_drv = 1'b0;
  logic        a_miso, a_sclk, a_mosi, a_cs_n, a_busy, a_done, a_drop;
  logic [31:0] a_rx;

  logic [7:0]  b_data = 8'd0;
  logic        b_dv = 1'b0, b_crc = 1'b0;
  logic        b_sclk, b_mosi, b_cs_n, b_busy, b_done, b_drop;
  logic [7:0]  b_rx;

  assign a_miso = a_loop ? a_mosi : a_miso_drv;

  spi_nbytes_tx #(.BYTE_NUM(4), .SPI_CLK_DIV(DIV_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data), .data_valid_i(a_dv), .crc_valid_i(a_crc),
    .spi_miso_i(a_miso), .spi_sclk_o(a_sclk), .spi_mosi_o(a_mosi), .spi_cs_n_o(a_cs_n),
    .busy_o(a_busy), .done_o(a_done), .drop_o(a_drop), .rx_data_o(a_rx)
  );

  spi_nbytes_tx #(.BYTE_NUM(1), .SPI_CLK_DIV(DIV_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data), .data_valid_i(b_dv), .crc_valid_i(b_crc),
    .spi_miso_i(b_mosi), .spi_sclk_o(b_sclk), .spi_mosi_o(b_mosi), .spi_cs_n_o(b_cs_n),
    .busy_o(b_busy), .done_o(b_done), .drop_o(b_drop), .rx_data_o(b_rx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame on DUT A; optional second frame injected at cycle inj_at, optional reset at rst_at.
  task automatic run_frame(input logic [31:0] data, input logic crc, input logic loop,
                           input logic [31:0] sword, input int inj_at, input int rst_at);
    int rises = 0, falls = 0, cs_low = 0, busy_hi = 0, done_at = 0, done_cnt = 0;
    int drop_cnt = 0, rx_chg = 0;
    logic [31:0] mosi_word = 32'd0, rx_seen = 32'd0, rx_prev;
    logic sclk_prev = 1'b0;
    a_loop = loop;
    a_miso_drv = sword[31];
    @(negedge clk);
    a_data = data; a_dv = 1'b1; a_crc = crc;
    rx_prev = a_rx;
    for (int k = 1; k <= LAT_A + 4; k++) begin
      @(negedge clk);
      if (a_sclk && !sclk_prev) begin
        rises++;
        mosi_word = {mosi_word[30:0], a_mosi};
      end
      if (!a_sclk && sclk_prev) begin
        falls++;
        if (falls < 32) a_miso_drv = sword[31 - falls];
      end
      sclk_prev = a_sclk;
      if (!a_cs_n) cs_low++;
      if (a_busy) busy_hi++;
      if (a_drop) drop_cnt++;
      if (a_done) begin
        done_cnt++;
        if (done_at == 0) begin done_at = k; rx_seen = a_rx; end
        rx_prev = a_rx;
      end else if (a_rx !== rx_prev) begin
        rx_chg++;
        rx_prev = a_rx;
      end
      if (k == 1) check_eq("drop_t1", 64'(a_drop), 64'(!crc));
      if (inj_at != 0 && k == inj_at + 1) check_eq("drop_busy", 64'(a_drop), 64'd1);
      if (rst_at != 0 && k == rst_at + 1) begin
        check_eq("rst_cs_n", 64'(a_cs_n), 64'd1);
        check_eq("rst_sclk", 64'(a_sclk), 64'd0);
        check_eq("rst_busy", 64'(a_busy), 64'd0);
        check_eq("rst_rx",   64'(a_rx),   64'd0);
      end
      a_dv  = (inj_at != 0 && k == inj_at);
      a_crc = a_dv ? 1'($urandom) : 1'b0;
      a_data = a_dv ? $urandom : data;
      rst   = (rst_at != 0 && k == rst_at);
    end
    a_dv = 1'b0; a_crc = 1'b0; rst = 1'b0;
    if (!crc) begin
      check_eq("rej_cs_low", 64'(cs_low), 64'd0);
      check_eq("rej_busy",   64'(busy_hi), 64'd0);
      check_eq("rej_done",   64'(done_cnt), 64'd0);
    end else if (rst_at != 0) begin
      check_eq("abort_done", 64'(done_cnt), 64'd0);
    end else begin
      check_eq("rises",    64'(rises), 64'(N_A));
      check_eq("mosi",     64'(mosi_word), 64'(data));
      check_eq("cs_low",   64'(cs_low), 64'(LAT_A - 1));
      check_eq("busy_hi",  64'(busy_hi), 64'(LAT_A));
      check_eq("done_at",  64'(done_at), 64'(LAT_A));
      check_eq("done_cnt", 64'(done_cnt), 64'd1);
      check_eq("rx_data",  64'(rx_seen), loop ? 64'(data) : 64'(sword));
      check_eq("drop_cnt", 64'(drop_cnt), (inj_at != 0) ? 64'd1 : 64'd0);
      check_eq("rx_stable", 64'(rx_chg), 64'd0);
    end
    repeat (3) @(negedge clk);
  endtask

  // One frame on DUT B (MISO looped to MOSI); also counts cycles MOSI is high under CS.
  task automatic run_small(input logic [7:0] data);
    int rises = 0, hi_cnt = 0, done_at = 0, exp_hi = 0;
    logic [7:0] mw = 8'd0, rxs = 8'd0;
    logic sp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (data[i]) exp_hi += (i == 0) ? 4 * DIV_B : 2 * DIV_B;
    end
    @(negedge clk);
    b_data = data; b_dv = 1'b1; b_crc = 1'b1;
    for (int k = 1; k <= LAT_B + 4; k++) begin
      @(negedge clk);
      b_dv = 1'b0; b_crc = 1'b0;
      if (b_sclk && !sp) begin rises++; mw = {mw[6:0], b_mosi}; end
      sp = b_sclk;
      if (!b_cs_n && b_mosi) hi_cnt++;
      if (b_done && done_at == 0) begin done_at = k; rxs = b_rx; end
    end
    check_eq("b_rises",   64'(rises), 64'(N_B));
    check_eq("b_mosi",    64'(mw), 64'(data));
    check_eq("b_mosi_hi", 64'(hi_cnt), 64'(exp_hi));
    check_eq("b_done_at", 64'(done_at), 64'(LAT_B));
    check_eq("b_rx",      64'(rxs), 64'(data));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_sclk0", 64'(a_sclk), 64'd0);
    check_eq("rst_mosi0", 64'(a_mosi), 64'd0);
    check_eq("rst_cs_n0", 64'(a_cs_n), 64'd1);
    check_eq("rst_busy0", 64'(a_busy), 64'd0);
    check_eq("rst_done0", 64'(a_done), 64'd0);
    check_eq("rst_drop0", 64'(a_drop), 64'd0);
    check_eq("rst_rx0",   64'(a_rx),   64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // crc_valid_i alone is ignored
    a_crc = 1'b1;
    @(negedge clk);
    a_crc = 1'b0;
    check_eq("crc_only_drop", 64'(a_drop), 64'd0);
    check_eq("crc_only_cs_n", 64'(a_cs_n), 64'd1);
    @(negedge clk);

    run_frame(32'hA5C30F96, 1'b1, 1'b1, 32'd0, 0, 0);
    run_frame($urandom, 1'b0, 1'b1, 32'd0, 0, 0);
    run_frame(32'hA5C30F96, 1'b1, 1'b1, 32'd0, 40, 0);
    run_frame($urandom, 1'b1, 1'b0, 32'hFFFFFFFF, 0, 0);
    run_frame($urandom, 1'b1, 1'b0, 32'h00000000, 0, 0);
    run_frame($urandom, 1'b1, 1'b0, $urandom, LAT_A, 0);
    run_frame($urandom, 1'b1, 1'b1, 32'd0, 0, 60);
    run_frame($urandom, 1'b1, 1'b1, 32'd0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_frame($urandom, 1'b1, 1'($urandom), $urandom,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAT_A)) : 0, 0);
    end

    run_small(8'h81);
    run_small(8'($urandom));
    run_small(8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_nbytes_tx.md
SPI_NBYTES_TX -- requirements
Module: spi_nbytes_tx

Interface
REQ-001 The block SHALL have parameter BYTE_NUM, default 4, meaning bytes per frame; N = 8*BYTE_NUM bits per frame.
REQ-002 The block SHALL have parameter SPI_CLK_DIV, default 25, meaning clk_i cycles per SCLK half-period; legal range 2..255.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port data_i, input, N bits: received frame, first-received byte in bits [N-1:N-8].
REQ-006 The block SHALL have port data_valid_i, input, 1 bit: one-cycle pulse, data_i valid.
REQ-007 The block SHALL have port crc_valid_i, input, 1 bit: one-cycle pulse, coincident with data_valid_i when the frame passed parity.
REQ-008 The block SHALL have port spi_miso_i, input, 1 bit: SPI slave data.
REQ-009 The block SHALL have port spi_sclk_o, output, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-010 The block SHALL have port spi_mosi_o, output, 1 bit: SPI master data, MSB first.
REQ-011 The block SHALL have port spi_cs_n_o, output, 1 bit: active-low chip select.
REQ-012 The block SHALL have port busy_o, output, 1 bit: high while a transaction is in progress.
REQ-013 The block SHALL have port done_o, output, 1 bit: one-cycle pulse, transaction complete.
REQ-014 The block SHALL have port drop_o, output, 1 bit: one-cycle pulse, a frame was rejected.
REQ-015 The block SHALL have port rx_data_o, output, N bits: MISO word captured during the last completed transaction.

Function
REQ-016 The block SHALL implement states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-017 In IDLE, a cycle T with data_valid_i=1 and crc_valid_i=1 SHALL load data_i into the TX shift register and enter SETUP at T+1.
REQ-018 In IDLE, data_valid_i=1 with crc_valid_i=0 SHALL pulse drop_o at T+1 and leave the state unchanged.
REQ-019 data_valid_i=1 in any state other than IDLE SHALL pulse drop_o at T+1 with no effect on the transaction in progress.
REQ-020 crc_valid_i=1 without data_valid_i SHALL be ignored.
REQ-021 spi_cs_n_o SHALL be low in SETUP, SHIFT and HOLD, and high in IDLE and DONE.
REQ-022 busy_o SHALL be high in SETUP, SHIFT, HOLD and DONE.
REQ-023 SETUP SHALL last SPI_CLK_DIV cycles with spi_sclk_o=0 and spi_mosi_o=bit N-1.
REQ-024 SHIFT SHALL last 2*N*SPI_CLK_DIV cycles, with spi_sclk_o toggling every SPI_CLK_DIV cycles starting high.
REQ-025 On each SCLK rising edge, spi_miso_i SHALL be shifted into the RX register LSB-side.
REQ-026 On each SCLK falling edge except the last, MOSI SHALL advance to the next lower bit.
REQ-027 SHIFT SHALL exit to HOLD with spi_sclk_o=0 after exactly N rising edges.
REQ-028 HOLD SHALL last SPI_CLK_DIV cycles.
REQ-029 DONE SHALL last one cycle, during which done_o=1 and rx_data_o takes the RX register value; DONE then returns to IDLE.
REQ-030 rx_data_o SHALL change only on DONE.
REQ-031 For a frame accepted at cycle T, done_o SHALL be high at cycle T+1+2*SPI_CLK_DIV*(N+1).
REQ-032 The divider counter and bit counter SHALL each be sized for their maximum count, and the bit counter SHALL not wrap within a frame.
REQ-033 An acceptance and done_o SHALL never occur in the same cycle; a frame arriving during DONE SHALL be dropped.

Reset
REQ-034 While rst_i=1, the block SHALL enter IDLE with spi_sclk_o=0, spi_mosi_o=0, spi_cs_n_o=1, busy_o=0, done_o=0, drop_o=0, rx_data_o=0, and all counters and shift registers cleared.
REQ-035 rst_i asserted mid-transaction SHALL abort it: outputs take reset values the following cycle, and no done_o is issued.

Verification
REQ-036 BYTE_NUM=4, DIV=2, MISO looped to MOSI, data_i=0xA5C30F96 with both valids at T -> cs_n low T+1..T+132, 32 SCLK pulses, MOSI sequence 1010_0101..., done_o at T+133, rx_data_o=0xA5C30F96.
REQ-037 data_valid_i=1 with crc_valid_i=0 -> drop_o=1 at T+1, cs_n stays 1, busy_o stays 0.
REQ-038 Second valid frame at T+40 during transfer -> drop_o at T+41; first transfer is bit-exact and completes at T+133.
REQ-039 MISO tied to 1, any frame -> rx_data_o=0xFFFFFFFF at done_o; MISO tied to 0 -> 0x00000000.
REQ-040 rst_i pulsed at T+60 -> at T+61 cs_n=1, sclk=0, busy_o=0; no done_o; a new frame afterwards completes normally.
REQ-041 BYTE_NUM=1, DIV=3, data 0x81 -> MOSI high only on the first and last bits, done_o at T+1+2*3*9=T+55.
